// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type and helpers for the sequential ALU.
// Imported by alu_seq and alu_iter_muldiv.
package alu_pkg;

   localparam int OPW = 4;

   localparam logic [OPW-1:0] OP_AND   = 4'b0000;
   localparam logic [OPW-1:0] OP_OR    = 4'b0001;
   localparam logic [OPW-1:0] OP_ADD   = 4'b0010;
   localparam logic [OPW-1:0] OP_XOR   = 4'b0011;
   localparam logic [OPW-1:0] OP_NOR   = 4'b0100;
   localparam logic [OPW-1:0] OP_SLTU  = 4'b0101;
   localparam logic [OPW-1:0] OP_SUB   = 4'b0110;
   localparam logic [OPW-1:0] OP_SLT   = 4'b0111;
   localparam logic [OPW-1:0] OP_MUL   = 4'b1000;
   localparam logic [OPW-1:0] OP_MULHU = 4'b1001;
   localparam logic [OPW-1:0] OP_DIVU  = 4'b1010;
   localparam logic [OPW-1:0] OP_REMU  = 4'b1011;

   localparam logic MODE_MUL = 1'b0;
   localparam logic MODE_DIV = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic logic is_iter_op(input logic [OPW-1:0] op);
      return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
   endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// lo is product low / quotient, hi is product high / remainder.
module alu_iter_muldiv
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] next_acc;
   logic [WIDTH-1:0]   opnd;
   logic [CW-1:0]      count;
   logic               busy;
   logic               div_mode;

   logic [WIDTH:0] mul_sum;
   logic [WIDTH:0] div_trial;
   logic [WIDTH:0] div_diff;

   // acc = {hi, lo}; multiply keeps the multiplier in lo, divide keeps the dividend/quotient in lo
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd};
      next_acc  = acc;
      if (div_mode == MODE_DIV) begin
         if (!div_diff[WIDTH]) begin
            next_acc = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
         end else begin
            next_acc = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
         end
      end else begin
         next_acc = {mul_sum, acc[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         opnd     <= '0;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_mode <= MODE_MUL;
      end else if (start) begin
         acc      <= {{WIDTH{1'b0}}, ((mode == MODE_DIV) ? a : b)};
         opnd     <= (mode == MODE_DIV) ? b : a;
         count    <= '0;
         busy     <= 1'b1;
         done     <= 1'b0;
         div_mode <= mode;
      end else if (busy) begin
         acc   <= next_acc;
         count <= count + CW'(1);
         if (count == CW'(WIDTH - 1)) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   assign lo = acc[WIDTH-1:0];
   assign hi = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative mul/div, with the
// result held registered until the consumer takes it.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int OPW   = alu_pkg::OPW
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OPW-1:0]   control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             illegal,
   output state_t           state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
   // out_valid stays high with stable outputs until that edge; in_valid is ignored unless in_ready.

   state_t next_state;

   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf;
   logic             alu_ill;
   logic [OPW-1:0]   op_q;
   logic             start;
   logic             load_alu;
   logic             load_iter;
   logic             clear_out;
   logic             iter_done;
   logic [WIDTH-1:0] iter_lo;
   logic [WIDTH-1:0] iter_hi;
   logic [WIDTH-1:0] iter_res;
   logic             iter_mode;

   assign sum  = A + B;
   assign diff = A - B;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      case (control)
         OP_AND:  alu_res = A & B;
         OP_OR:   alu_res = A | B;
         OP_XOR:  alu_res = A ^ B;
         OP_NOR:  alu_res = ~(A | B);
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_ADD: begin
            alu_res = sum;
            alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff;
            alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
         end
         OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
         default: alu_ill = 1'b1;
      endcase
   end

   assign iter_mode = ((control == OP_DIVU) || (control == OP_REMU)) ? MODE_DIV : MODE_MUL;
   assign iter_res  = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? iter_lo : iter_hi;

   alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (iter_mode),
      .a     (A),
      .b     (B),
      .done  (iter_done),
      .lo    (iter_lo),
      .hi    (iter_hi)
   );

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      start      = 1'b0;
      load_alu   = 1'b0;
      load_iter  = 1'b0;
      clear_out  = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (is_iter_op(control)) begin
                  start      = 1'b1;
                  next_state = BUSY;
               end else begin
                  load_alu   = 1'b1;
                  next_state = DONE;
               end
            end
         end
         BUSY: begin
            if (iter_done) begin
               load_iter  = 1'b1;
               next_state = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               clear_out  = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are cleared on the handshake so zero reads 0 whenever out_valid is low
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         op_q     <= OP_AND;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         illegal  <= 1'b0;
      end else begin
         state <= next_state;
         if (start) begin
            op_q <= control;
         end
         if (load_alu) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
            illegal  <= alu_ill;
         end else if (load_iter) begin
            result   <= iter_res;
            zero     <= (iter_res == '0);
            overflow <= 1'b0;
            illegal  <= 1'b0;
         end else if (clear_out) begin
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
            illegal  <= 1'b0;
         end
      end
   end

endmodule
